// File: rtl/cordic_pkg.sv
// Shared constants for the polar CORDIC: FSM encoding, arctangent table in degrees,
// gain compensation constant and angle constants.
package cordic_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int ATAN_FRAC = 22;
  localparam int ATAN_N    = 24;

  // atan(2^-i) in degrees, Q9.22, truncated
  localparam logic [31:0] ATAN_Q22 [ATAN_N] = '{
    32'd188743680, 32'd111421900, 32'd58872272, 32'd29884484,
    32'd15000233,  32'd7507429,   32'd3754630,  32'd1877429,
    32'd938729,    32'd469366,    32'd234683,   32'd117341,
    32'd58670,     32'd29335,     32'd14667,    32'd7333,
    32'd3666,      32'd1833,      32'd916,      32'd458,
    32'd229,       32'd114,       32'd57,       32'd28
  };

  // Gain compensation K = 0.60725 in Q0.16
  localparam int          K_FRAC = 16;
  localparam logic [15:0] K_Q16  = 16'd39797;

  localparam int DEG_180 = 180;
  localparam int DEG_360 = 360;

  function automatic logic [31:0] atan_entry(input int i, input int frac);
    return ATAN_Q22[i] >> (ATAN_FRAC - frac);
  endfunction

endpackage

// File: rtl/cordic_vec_core.sv
// Single-channel iterative CORDIC vectoring datapath: drives y to zero and
// accumulates the rotated angle in z, one micro-rotation per enabled cycle.
module cordic_vec_core
  import cordic_pkg::*;
#(
  parameter int XY_W     = 13,
  parameter int ANG_W    = 19,
  parameter int ANG_FRAC = 10,
  parameter int N_ITER   = 16,
  parameter int GUARD    = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         step,
  input  logic signed [XY_W+1:0]       x_in,
  input  logic signed [XY_W+1:0]       y_in,
  output logic signed [XY_W+GUARD+1:0] x_out,
  output logic signed [ANG_W-1:0]      z_out,
  output logic                         last
);

  localparam int PW   = XY_W + 2 + GUARD;
  localparam int IT_W = $clog2(N_ITER);

  logic signed [PW-1:0]    x_q, y_q, x_sh, y_sh;
  logic signed [ANG_W-1:0] z_q, z_step;
  logic [IT_W-1:0]         iter_q;

  assign x_sh   = x_q >>> iter_q;
  assign y_sh   = y_q >>> iter_q;
  assign z_step = ANG_W'(atan_entry(int'(iter_q), ANG_FRAC));

  // Guard fraction bits keep the residual y meaningful after the shifts underflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      iter_q <= '0;
    end else if (load) begin
      x_q    <= {x_in, {GUARD{1'b0}}};
      y_q    <= {y_in, {GUARD{1'b0}}};
      z_q    <= '0;
      iter_q <= '0;
    end else if (step) begin
      if (!y_q[PW-1]) begin
        x_q <= x_q + y_sh;
        y_q <= y_q - x_sh;
        z_q <= z_q + z_step;
      end else begin
        x_q <= x_q - y_sh;
        y_q <= y_q + x_sh;
        z_q <= z_q - z_step;
      end
      iter_q <= iter_q + IT_W'(1);
    end
  end

  assign x_out = x_q;
  assign z_out = z_q;
  assign last  = (iter_q == IT_W'(N_ITER - 1));

endmodule

// File: rtl/cordic_polar_mc.sv
// Multi-channel cartesian-to-polar converter: one shared CORDIC core is time-multiplexed
// over the enabled channels, lowest index first, with per-channel registered results.
module cordic_polar_mc
  import cordic_pkg::*;
#(
  parameter  int XY_W     = 13,
  parameter  int ANG_FRAC = 10,
  parameter  int N_ITER   = 16,
  parameter  int N_CH     = 4,
  localparam int ANG_W    = 9 + ANG_FRAC
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [N_CH-1:0]            ch_en,
  input  logic [N_CH*XY_W-1:0]       x,
  input  logic [N_CH*XY_W-1:0]       y,
  output logic                       busy,
  output logic                       done,
  output logic [N_CH*ANG_W-1:0]      angle,
  output logic [N_CH*(XY_W+1)-1:0]   mag,
  output state_t                     state_dbg
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int GUARD = 12;
  localparam int PW    = XY_W + 2 + GUARD;
  localparam int MAG_W = XY_W + 1;
  localparam int AW1   = ANG_W + 1;
  localparam int PRW   = PW + K_FRAC + 1;
  localparam int SH    = K_FRAC + GUARD;

  localparam logic signed [AW1-1:0] A180    = AW1'(DEG_180 * (2 ** ANG_FRAC));
  localparam logic signed [AW1-1:0] A360    = AW1'(DEG_360 * (2 ** ANG_FRAC));
  localparam logic signed [PRW-1:0] MAG_MAX = PRW'((2 ** MAG_W) - 1);

  state_t                  state;
  logic [N_CH*XY_W-1:0]    x_lat, y_lat;
  logic [N_CH-1:0]         pend;
  logic [CH_W-1:0]         ch_q, sel_idx;
  logic                    off_q, yz_q;

  logic signed [XY_W-1:0]  xs, ys;
  logic signed [XY_W+1:0]  xe, ye, core_xi, core_yi;
  logic                    x_neg;
  logic signed [PW-1:0]    core_x;
  logic signed [ANG_W-1:0] core_z;
  logic                    core_last;

  logic signed [AW1-1:0]   ang_sum;
  logic [ANG_W-1:0]        angle_w;
  logic signed [PRW-1:0]   prod, mag_full;
  logic [MAG_W-1:0]        mag_w;

  // Lowest-index pending channel and its quadrant pre-map
  always_comb begin
    sel_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend[i]) sel_idx = CH_W'(i);
    end
    xs      = $signed(x_lat[sel_idx*XY_W +: XY_W]);
    ys      = $signed(y_lat[sel_idx*XY_W +: XY_W]);
    xe      = (XY_W+2)'(xs);
    ye      = (XY_W+2)'(ys);
    x_neg   = xs[XY_W-1];
    core_xi = x_neg ? -xe : xe;
    core_yi = x_neg ? -ye : ye;
  end

  cordic_vec_core #(
    .XY_W     (XY_W),
    .ANG_W    (ANG_W),
    .ANG_FRAC (ANG_FRAC),
    .N_ITER   (N_ITER),
    .GUARD    (GUARD)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .load  (state == S_LOAD),
    .step  (state == S_ITER),
    .x_in  (core_xi),
    .y_in  (core_yi),
    .x_out (core_x),
    .z_out (core_z),
    .last  (core_last)
  );

  // A zero y input lands exactly on 0 or +180, bypassing CORDIC residual error
  always_comb begin
    ang_sum = AW1'(core_z);
    if (yz_q) ang_sum = '0;
    if (off_q) ang_sum = ang_sum + A180;
    if (ang_sum <= -A180) ang_sum = ang_sum + A360;
    else if (ang_sum > A180) ang_sum = ang_sum - A360;
    angle_w = ANG_W'(ang_sum);

    prod     = PRW'(core_x) * PRW'($signed({1'b0, K_Q16}));
    mag_full = (prod + (PRW'(1) <<< (SH - 1))) >>> SH;
    if (mag_full < 0) mag_w = '0;
    else if (mag_full > MAG_MAX) mag_w = '1;
    else mag_w = MAG_W'(mag_full);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      x_lat <= '0;
      y_lat <= '0;
      pend  <= '0;
      ch_q  <= '0;
      off_q <= 1'b0;
      yz_q  <= 1'b0;
      angle <= '0;
      mag   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_lat <= x;
            y_lat <= y;
            pend  <= ch_en;
            busy  <= 1'b1;
            if (|ch_en) begin
              state <= S_LOAD;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          ch_q          <= sel_idx;
          off_q         <= x_neg;
          yz_q          <= (ys == '0);
          pend[sel_idx] <= 1'b0;
          state         <= S_ITER;
        end
        S_ITER: begin
          if (core_last) state <= S_POST;
        end
        S_POST: begin
          angle[ch_q*ANG_W +: ANG_W] <= angle_w;
          mag[ch_q*MAG_W +: MAG_W]   <= mag_w;
          if (|pend) begin
            state <= S_LOAD;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_cordic_polar_mc.sv
// Self-checking bench for cordic_polar_mc: directed corner runs plus random vectors
// compared against an atan2/sqrt reference model.
module tb_cordic_polar_mc;
  import cordic_pkg::*;

  localparam int  XY_W     = 13;
  localparam int  ANG_FRAC = 10;
  localparam int  N_ITER   = 16;
  localparam int  N_CH     = 4;
  localparam int  ANG_W    = 9 + ANG_FRAC;
  localparam int  MAG_W    = XY_W + 1;
  localparam int  A180     = 180 * 1024;
  localparam int  A360     = 360 * 1024;
  localparam int  CONV_LAT = N_ITER + 2;
  localparam real PI       = 3.14159265358979323846;

  logic                   clock, reset, start, busy, done;
  logic [N_CH-1:0]        ch_en;
  logic [N_CH*XY_W-1:0]   x, y;
  logic [N_CH*ANG_W-1:0]  angle;
  logic [N_CH*MAG_W-1:0]  mag;
  state_t                 state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int xv[N_CH], yv[N_CH];
  int exp_ang[N_CH], exp_mag[N_CH], ang_tol[N_CH];
  logic [31:0] exp_q[$];

  cordic_polar_mc #(
    .XY_W     (XY_W),
    .ANG_FRAC (ANG_FRAC),
    .N_ITER   (N_ITER),
    .N_CH     (N_CH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ch_en     (ch_en),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .angle     (angle),
    .mag       (mag),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
    longint d;
    n_checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // reference model
  function automatic int ref_angle(input int xi, input int yi);
    real d;
    int  a;
    if (xi == 0 && yi == 0) return 0;
    d = $atan2(real'(yi), real'(xi)) * 180.0 / PI;
    a = int'(d * 1024.0);
    if (a <= -A180) a += A360;
    else if (a > A180) a -= A360;
    return a;
  endfunction

  function automatic int ref_mag(input int xi, input int yi);
    return int'($sqrt(real'(xi * xi + yi * yi)));
  endfunction

  task automatic model_start(input logic [N_CH-1:0] en);
    for (int c = 0; c < N_CH; c++) begin
      if (en[c]) begin
        exp_ang[c] = ref_angle(xv[c], yv[c]);
        exp_mag[c] = ref_mag(xv[c], yv[c]);
        ang_tol[c] = (yv[c] == 0) ? 0 : 51;
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      exp_q.push_back(32'(exp_ang[c]));
      exp_q.push_back(32'(exp_mag[c]));
    end
  endtask

  task automatic check_outputs(input string tag);
    int obs_a, obs_m, e_a, e_m;
    for (int c = 0; c < N_CH; c++) begin
      e_a   = int'($signed(exp_q.pop_front()));
      e_m   = int'(exp_q.pop_front());
      obs_a = int'($signed(angle[c*ANG_W +: ANG_W]));
      obs_m = int'(mag[c*MAG_W +: MAG_W]);
      if (obs_a - e_a > A180) e_a += A360;
      else if (e_a - obs_a > A180) e_a -= A360;
      check_val($sformatf("%s_ang%0d", tag, c), obs_a, e_a, ang_tol[c]);
      check_val($sformatf("%s_mag%0d", tag, c), obs_m, e_m, 1);
    end
  endtask

  // driver tasks
  task automatic drive_xy();
    for (int c = 0; c < N_CH; c++) begin
      x[c*XY_W +: XY_W] = XY_W'(xv[c]);
      y[c*XY_W +: XY_W] = XY_W'(yv[c]);
    end
  endtask

  task automatic scramble_inputs();
    for (int c = 0; c < N_CH; c++) begin
      x[c*XY_W +: XY_W] = XY_W'($urandom);
      y[c*XY_W +: XY_W] = XY_W'($urandom);
    end
  endtask

  task automatic rand_xy();
    for (int c = 0; c < N_CH; c++) begin
      do begin
        xv[c] = int'($urandom_range(0, 8191)) - 4096;
        yv[c] = int'($urandom_range(0, 8191)) - 4096;
      end while (xv[c] * xv[c] + yv[c] * yv[c] < 256);
    end
  endtask

  task automatic do_conv(input string tag, input logic [N_CH-1:0] en, input int restart_at);
    int cyc, exp_lat, extra;
    exp_lat = $countones(en) * CONV_LAT + 1;
    @(negedge clock);
    drive_xy();
    ch_en = en;
    start = 1'b1;
    model_start(en);
    @(negedge clock);
    start = 1'b0;
    cyc   = 1;
    scramble_inputs();
    ch_en = ~en;
    check_val($sformatf("%s_busy", tag), busy, 1, 0);
    while (done !== 1'b1 && cyc < 4 * N_CH * CONV_LAT) begin
      @(negedge clock);
      cyc++;
      start = (cyc == restart_at);
    end
    start = 1'b0;
    check_val($sformatf("%s_lat", tag), cyc, exp_lat, 0);
    check_outputs(tag);
    extra = 0;
    for (int i = 0; i < CONV_LAT; i++) begin
      @(negedge clock);
      if (i == 0) check_val($sformatf("%s_idle_busy", tag), busy, 0, 0);
      if (done) extra++;
    end
    check_val($sformatf("%s_xdone", tag), extra, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    ch_en = '0;
    x     = '0;
    y     = '0;
    for (int c = 0; c < N_CH; c++) begin
      xv[c] = 0; yv[c] = 0; exp_ang[c] = 0; exp_mag[c] = 0; ang_tol[c] = 0;
    end
    repeat (3) @(negedge clock);
    check_val("rst_busy", busy, 0, 0);
    check_val("rst_done", done, 0, 0);
    check_val("rst_state", int'(state_dbg), int'(S_IDLE), 0);
    model_start('0);
    check_outputs("rst");
    reset = 1'b1;
    @(negedge clock);

    // four quadrants, all channels
    xv = '{100, 0, -100, -100};
    yv = '{100, -100, 0, -100};
    do_conv("quad", 4'b1111, 0);

    // partial enable: ch1/ch3 keep earlier results
    xv = '{50, 777, 50, -5};
    yv = '{0, -33, 0, 900};
    do_conv("partial", 4'b0101, 0);

    do_conv("none", 4'b0000, 0);

    // second start while busy is ignored
    rand_xy();
    do_conv("restart", 4'b1111, 5);

    // extremes of the input range
    xv = '{-4096, -4096, 4095, 1000};
    yv = '{0, -4096, -1, 2000};
    do_conv("extreme", 4'b1111, 0);

    // abort by reset mid-conversion
    rand_xy();
    @(negedge clock);
    drive_xy();
    ch_en = '1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b0;
    #1;
    check_val("abort_busy", busy, 0, 0);
    check_val("abort_done", done, 0, 0);
    check_val("abort_state", int'(state_dbg), int'(S_IDLE), 0);
    for (int c = 0; c < N_CH; c++) begin
      exp_ang[c] = 0; exp_mag[c] = 0; ang_tol[c] = 0;
    end
    model_start('0);
    check_outputs("abort");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    repeat (8) begin
      rand_xy();
      do_conv("rand", N_CH'($urandom_range(1, 15)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_polar_mc.md
CORDIC_POLAR_MC -- requirements
Module: cordic_polar_mc

Interface
REQ-001 Parameter XY_W, default 13: signed width of each x/y component.
REQ-002 Parameter ANG_FRAC, default 10: fractional bits of angle; angle width ANG_W = 9+ANG_FRAC (signed 9Q ANG_FRAC, degrees).
REQ-003 Parameter N_ITER, default 16: CORDIC micro-rotations per channel, legal range 8..24.
REQ-004 Parameter N_CH, default 4: number of channels, legal range 1..16.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse requesting conversion of all enabled channels.
REQ-008 ch_en  input  N_CH  per-channel enable mask, sampled with start.
REQ-009 x  input  N_CH*XY_W  packed signed X components, channel 0 in LSBs.
REQ-010 y  input  N_CH*XY_W  packed signed Y components, same packing.
REQ-011 busy  output  1  high from cycle after accepted start until done cycle inclusive.
REQ-012 done  output  1  one-cycle pulse when all enabled channels are finished.
REQ-013 angle  output  N_CH*ANG_W  packed signed angles, degrees, range (-180,+180].
REQ-014 mag  output  N_CH*(XY_W+1)  packed unsigned magnitudes, gain-compensated.

Function
REQ-015 start SHALL be accepted only in IDLE; start while busy SHALL be ignored without side effect.
REQ-016 On accepted start, x, y and ch_en SHALL be latched into internal registers; inputs may change afterwards.
REQ-017 FSM states: IDLE, LOAD, ITER, POST, DONE.
REQ-018 IDLE->LOAD on accepted start when any ch_en bit set; IDLE->DONE when ch_en is all zero.
REQ-019 LOAD (1 cycle): select lowest-index pending enabled channel, apply quadrant pre-map, clear angle accumulator.
REQ-020 Pre-map: x<0 -> core input (-x, -y) with +180 deg offset pending; x>=0 -> (x, y), no offset; internal x/y path width XY_W+2 so -(-2^(XY_W-1)) and CORDIC growth do not overflow.
REQ-021 ITER: exactly N_ITER cycles of vectoring, iteration i shifts by i and adds/subtracts atan(2^-i) from table, direction from sign of residual y.
REQ-022 POST (1 cycle): add offset (+180 if pending), then wrap to (-180,+180] (result <= -180 gets +360, > +180 gets -360); multiply final x by gain constant K=0.60725 (Q0.16), round to nearest, saturate to XY_W+1 bits; write angle/mag of that channel only.
REQ-023 After POST: next pending enabled channel -> LOAD, none left -> DONE.
REQ-024 DONE (1 cycle): done=1, busy=1, then IDLE.
REQ-025 Latency: k enabled channels -> done asserted k*(N_ITER+2)+1 cycles after start cycle; k=0 -> 1 cycle.
REQ-026 Disabled channels SHALL keep previous angle/mag unchanged.
REQ-027 x=0,y=0 SHALL give angle 0, mag 0; x<0,y=0 SHALL give +180 exactly.
REQ-028 Outputs SHALL be registered and stable between writes.
REQ-029 Angle accuracy: |error| <= 0.05 deg for mag >= 16 with default parameters.

Reset
REQ-030 reset low SHALL immediately force state IDLE, busy=0, done=0, all angle and mag bits 0, latched inputs 0.
REQ-031 reset asserted mid-conversion SHALL abort without further output writes; first start after release behaves as from power-up.

Structure
REQ-032 Shared package cordic_pkg: FSM state encoding, atan(2^-i) table in degrees (Q9.22, truncated to ANG_FRAC per instance), gain constant K, 180/360 constants.
REQ-033 One sub-module cordic_vec_core: single-channel iterative vectoring datapath (x/y/z registers, shift-add, iteration counter); top holds FSM, channel scheduler, pre-map, POST and output registers.

Verification (defaults: XY_W=13, ANG_FRAC=10, N_ITER=16, N_CH=4)
REQ-034 ch0=(100,100), ch1=(0,-100), ch2=(-100,0), ch3=(-100,-100), ch_en=1111 -> angles 46080, -92160, 184320, -138240 (+-51 LSB); mags 141, 100, 100, 141 (+-1); done 73 cycles after start.
REQ-035 ch_en=0101 after REQ-034 run with new inputs (50,0) on ch0/ch2 -> ch0, ch2 angle 0 mag 50; ch1, ch3 unchanged; done 37 cycles after start.
REQ-036 ch_en=0000 -> done exactly 1 cycle after start, no outputs change.
REQ-037 Second start pulse 5 cycles after first -> ignored; single done at original latency, results from first input set.
REQ-038 reset low at cycle 20 of conversion -> busy, done, all outputs 0 immediately; new start after release completes normally.
REQ-039 Extremes ch0=(-4096,0), ch1=(-4096,-4096), ch2=(4095,-1) -> angle +184320, -138240 (+-51), -14 (+-51); mag 4096, 5793, 4095 (+-1), no overflow.
